tdm_mux_8: RTL and testbench

//  8:1 time-division multiplexer, the transmit end of the 8-way select path.

---
 rtl/tdm_mux_8_pkg.sv | 18 +
 rtl/tdm_slot_counter.sv | 50 +++++
 rtl/tdm_mux_8.sv | 119 +++++++++++
 tb/tb_tdm_mux_8.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_8_pkg.sv
// Shared constants, slot type and FSM state encodings for the 8-way TDM transmit path.
package tdm_mux_8_pkg;

   localparam int unsigned NSLOT  = 8;
   localparam int unsigned SLOT_W = 3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   typedef logic [SLOT_W-1:0] slot_t;

   // Slot index after the current cycle, assuming the frame keeps running.
   function automatic slot_t next_slot(slot_t slot, logic slot_end);
      return slot_end ? slot + slot_t'(1) : slot;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Dwell counter plus 3-bit slot counter; flags the last cycle of a slot and of a frame.
module tdm_slot_counter
   import tdm_mux_8_pkg::*;
#(
   parameter int unsigned DWELL = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clr,
   input  logic  adv,
   output slot_t slot,
   output logic  slot_end,
   output logic  frame_end
);

   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   slot_t            slot_q, slot_d;

   assign slot_end  = (dcnt_q == CNT_W'(DWELL - 1));
   assign frame_end = slot_end && (slot_q == slot_t'(NSLOT - 1));
   assign slot      = slot_q;

   always_comb begin
      dcnt_d = dcnt_q;
      slot_d = slot_q;
      if (clr) begin
         dcnt_d = '0;
         slot_d = '0;
      end else if (adv) begin
         if (slot_end) begin
            dcnt_d = '0;
            slot_d = slot_q + slot_t'(1);
         end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt_q <= '0;
         slot_q <= '0;
      end else begin
         dcnt_q <= dcnt_d;
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/tdm_mux_8.sv
// 8:1 time-division multiplexer: snapshots eight channels per frame and serialises them
// on O with the slot index on S3..S1 and a frame marker F.
module tdm_mux_8
   import tdm_mux_8_pkg::*;
#(
   parameter int unsigned DWELL = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic I1,
   input  logic I2,
   input  logic I3,
   input  logic I4,
   input  logic I5,
   input  logic I6,
   input  logic I7,
   input  logic I8,
   output logic O,
   output logic S1,
   output logic S2,
   output logic S3,
   output logic F,
   output logic busy
);

   logic [1:0]       state_q, state_d;
   logic [NSLOT-1:0] snap_q, snap_d;
   logic             o_q, o_d;
   slot_t            s_q, s_d;
   logic             f_q, f_d;

   logic  frame_start, go_idle, clr, adv;
   slot_t slot, nxt;
   logic  slot_end, frame_end;

   tdm_slot_counter #(
      .DWELL (DWELL),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .adv       (adv),
      .slot      (slot),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // en only decides what happens at frame end; a running frame is never cut short.
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      go_idle     = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               frame_start = 1'b1;
               state_d     = RUN;
            end
         end
         RUN, DRAIN: begin
            if (frame_end) begin
               frame_start = en;
               go_idle     = ~en;
               state_d     = en ? RUN : IDLE;
            end else begin
               state_d = en ? RUN : DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr = frame_start | go_idle;
   assign adv = (state_q != IDLE) & ~clr;
   assign nxt = next_slot(slot, slot_end);

   always_comb begin
      snap_d = snap_q;
      o_d    = 1'b0;
      s_d    = '0;
      f_d    = 1'b0;
      if (frame_start) begin
         // Snapshot is not visible yet, so slot 0 data comes straight from the input.
         snap_d = {I8, I7, I6, I5, I4, I3, I2, I1};
         o_d    = I1;
         f_d    = 1'b1;
      end else if (state_d != IDLE) begin
         o_d = snap_q[nxt];
         s_d = nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         o_q     <= 1'b0;
         s_q     <= '0;
         f_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         o_q     <= o_d;
         s_q     <= s_d;
         f_q     <= f_d;
      end
   end

   assign O    = o_q;
   assign S1   = s_q[0];
   assign S2   = s_q[1];
   assign S3   = s_q[2];
   assign F    = f_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tdm_mux_8.sv
// Scoreboard bench for tdm_mux_8 at DWELL=1 and DWELL=4 sharing one stimulus stream,
// with a behavioural demux_8 loopback on each instance.
module tb_tdm_mux_8;

   typedef struct packed {
      logic [7:0] snap;
      logic       last;
      logic       f;
      logic [2:0] s;
      logic       o;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] in_bus;

   logic o1, s1_1, s2_1, s3_1, f1, b1;
   logic o4, s1_4, s2_4, s3_4, f4, b4;
   logic [5:0] obs [2];

   ent_t       mem [2][256];
   int         wr [2] = '{0, 0};
   int         rd [2] = '{0, 0};
   int         rem [2] = '{0, 0};
   logic [7:0] dmx [2];
   ent_t       model_e, mon_e;
   int         dw;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   tdm_mux_8 #(.DWELL(1), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .en(en),
      .I1(in_bus[0]), .I2(in_bus[1]), .I3(in_bus[2]), .I4(in_bus[3]),
      .I5(in_bus[4]), .I6(in_bus[5]), .I7(in_bus[6]), .I8(in_bus[7]),
      .O(o1), .S1(s1_1), .S2(s2_1), .S3(s3_1), .F(f1), .busy(b1)
   );

   tdm_mux_8 #(.DWELL(4), .CNT_W(8)) u4 (
      .clk(clk), .rst(rst), .en(en),
      .I1(in_bus[0]), .I2(in_bus[1]), .I3(in_bus[2]), .I4(in_bus[3]),
      .I5(in_bus[4]), .I6(in_bus[5]), .I7(in_bus[6]), .I8(in_bus[7]),
      .O(o4), .S1(s1_4), .S2(s2_4), .S3(s3_4), .F(f4), .busy(b4)
   );

   // {busy, O, S3, S2, S1, F}
   assign obs[0] = {b1, o1, s3_1, s2_1, s1_1, f1};
   assign obs[1] = {b4, o4, s3_4, s2_4, s1_4, f4};

   task automatic check(input string name, input int k, input logic [7:0] got,
                        input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s dwell=%0d t=%0t got=%h want=%h", name, (k == 0) ? 1 : 4, $time,
                  got, want);
      end
   endtask

   // Reference model: at each edge a frame starts when idle or on the last cycle of a frame
   // with en high; a frame is 8 slots of DWELL cycles each, from a snapshot of the inputs.
   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            dw = (k == 0) ? 1 : 4;
            if (rst) begin
               rem[k] = 0;
            end else if (rem[k] <= 1 && en) begin
               for (int c = 0; c < 8 * dw; c++) begin
                  model_e.snap = in_bus;
                  model_e.s    = 3'(c / dw);
                  model_e.o    = in_bus[c/dw];
                  model_e.f    = (c == 0);
                  model_e.last = (c == 8 * dw - 1);
                  mem[k][wr[k] & 255] = model_e;
                  wr[k]++;
               end
               rem[k] = 8 * dw;
            end else if (rem[k] > 0) begin
               rem[k]--;
            end
         end
      end
   end

   // Monitor: pops one expected cycle per instance while frames are pending, else expects idle.
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            for (int k = 0; k < 2; k++) begin
               check("reset_zero", k, {2'b00, obs[k]}, 8'h00);
               rd[k] = wr[k];
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (rd[k] != wr[k]) begin
                  mon_e = mem[k][rd[k] & 255];
                  rd[k]++;
                  check("frame_out", k, {2'b00, obs[k]},
                        {2'b00, 1'b1, mon_e.o, mon_e.s, mon_e.f});
                  dmx[k][obs[k][3:1]] = obs[k][4];
                  if (mon_e.last) check("demux_loop", k, dmx[k], mon_e.snap);
               end else begin
                  check("idle_out", k, {2'b00, obs[k]}, 8'h00);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      in_bus = 8'h00;
      step(3);
      rst = 1'b0;
      step(3);

      // Single frame: I1..I8 = 1,0,1,1,0,0,0,1
      in_bus = 8'b1000_1101;
      en     = 1'b1;
      step(1);
      en = 1'b0;
      step(40);

      // Snapshot: inputs flip during the frame, only the next frame sees them
      in_bus = 8'h00;
      en     = 1'b1;
      step(3);
      in_bus = 8'hff;
      step(13);
      en = 1'b0;
      step(40);

      // Continuous run with changing inputs
      en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_bus = 8'($urandom);
         step(1);
      end
      en = 1'b0;
      step(40);

      // Drain: drop en mid-frame, then re-raise it before frame end
      in_bus = 8'($urandom);
      en     = 1'b1;
      step(4);
      en = 1'b0;
      step(20);
      in_bus = 8'($urandom);
      en     = 1'b1;
      step(4);
      en = 1'b0;
      step(2);
      en = 1'b1;
      step(10);
      en = 1'b0;
      step(40);

      // Random traffic with occasional mid-cycle resets
      for (int i = 0; i < 300; i++) begin
         en     = ($urandom % 4) != 0;
         in_bus = 8'($urandom);
         if ($urandom % 60 == 0) begin
            rst = 1'b1;
            step(1 + int'($urandom % 2));
            rst = 1'b0;
         end
         step(1);
      end

      // Reset in the middle of a long-dwell frame
      en     = 1'b0;
      step(40);
      in_bus = 8'($urandom);
      en     = 1'b1;
      step(22);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      en  = 1'b0;
      step(10);

      // Final frame after reset, then drain to idle
      in_bus = 8'($urandom);
      en     = 1'b1;
      step(1);
      en = 1'b0;
      step(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
